fetch_btb: RTL and testbench

// Parametrised next-generation fetch stage: owns the architectural fetch PC, and

---
 rtl/fetch_btb_if.sv | 35 +++
 rtl/fetch_btb.sv | 116 +++++++++++
 tb/tb_fetch_btb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_btb_if.sv
// Fetch-stage bus: redirect sources, BTB training port and fetch outputs.
// The core side drives controls and training (master); the fetch stage
// drives the fetch PC and the prediction (slave).
interface fetch_btb_if #(
    parameter int XLEN = 32
);
    logic            stall_core_i;
    logic            iret_i;
    logic [XLEN-1:0] exc_return_pc_i;
    logic            exc_occured_i;
    logic            mispred_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] pc_o;
    logic            pred_o;
    logic            taken_o;
    logic [XLEN-1:0] pred_pc_o;

    modport master (
        output stall_core_i, iret_i, exc_return_pc_i, exc_occured_i,
        output mispred_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  pc_o, pred_o, taken_o, pred_pc_o
    );

    modport slave (
        input  stall_core_i, iret_i, exc_return_pc_i, exc_occured_i,
        input  mispred_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output pc_o, pred_o, taken_o, pred_pc_o
    );
endinterface

// File: rtl/fetch_btb.sv
// Fetch stage: owns the fetch PC, picks the next PC from the redirect
// sources or the prediction, and holds a direct-mapped BTB with 2-bit
// saturating direction counters trained by the branch-resolve stage.
module fetch_btb #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h1000,
    parameter logic [XLEN-1:0] EXC_PC      = 32'h2000,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    fetch_btb_if.slave  bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;

    logic             valid_q  [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic             rd_taken;
    logic [XLEN-1:0]  rd_next_pc;

    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;

    // The two low bits of a branch PC never select or tag an entry.
    logic             unused_upd_lsb;
    assign unused_upd_lsb = ^bus.upd_pc_i[1:0];

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_tag = pc_q[XLEN-1:IDX+2];
    assign wr_idx = bus.upd_pc_i[IDX+1:2];
    assign wr_tag = bus.upd_pc_i[XLEN-1:IDX+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Combinational lookup on the current fetch PC; reflects the table
    // contents before any training write landing on this same edge.
    always_comb begin
        rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken   = rd_hit && ctr_q[rd_idx][1];
        rd_next_pc = rd_taken ? target_q[rd_idx] : (pc_q + PC_STEP);
    end

    assign bus.pc_o      = pc_q;
    assign bus.pred_o    = rd_hit;
    assign bus.taken_o   = rd_taken;
    assign bus.pred_pc_o = rd_next_pc;

    // Next-PC selection; iret outranks exception, and only iret honours stall.
    always_comb begin
        pc_d = rd_next_pc;
        if (bus.iret_i) begin
            pc_d = bus.stall_core_i ? bus.exc_return_pc_i
                                    : (bus.exc_return_pc_i + PC_STEP);
        end else if (bus.exc_occured_i) begin
            pc_d = EXC_PC;
        end else if (bus.mispred_i) begin
            pc_d = bus.redirect_pc_i;
        end else if (bus.stall_core_i) begin
            pc_d = pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Valid bits and direction counters: saturating train on hit,
    // allocate weakly-taken on a taken miss, ignore a not-taken miss.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bus.upd_valid_i) begin
            if (wr_hit) begin
                if (bus.upd_taken_i) begin
                    if (ctr_q[wr_idx] != 2'b11) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                    end
                end else if (ctr_q[wr_idx] != 2'b00) begin
                    ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                end
            end else if (bus.upd_taken_i) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target payload; every taken resolve rewrites both (the tag is
    // unchanged on a hit), and an asserted reset blocks the write.
    always_ff @(posedge clk_i) begin
        if (rsn_i && bus.upd_valid_i && bus.upd_taken_i) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= bus.upd_target_i;
        end
    end
endmodule

// File: tb/tb_fetch_btb.sv
// Bench for fetch_btb: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against a behavioural model.
module tb_fetch_btb;
    localparam int N = 16;

    bit clk = 1'b0;
    bit rsn = 1'b0;
    bit check_en = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_btb_if #(.XLEN(32)) bus ();

    fetch_btb #(
        .XLEN(32), .RESET_PC(32'h1000), .EXC_PC(32'h2000), .BTB_ENTRIES(N)
    ) u_dut (
        .clk_i(clk),
        .rsn_i(rsn),
        .bus  (bus.slave)
    );

    // Behavioural model: a table keyed by word address modulo N, tag is the
    // rest of the address above the index.
    bit [31:0] m_pc;
    bit        m_valid [N];
    bit [31:0] m_tag   [N];
    bit [31:0] m_tgt   [N];
    int        m_ctr   [N];

    function automatic int m_idx(bit [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic bit [31:0] m_tagof(bit [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_hit();
        int i = m_idx(m_pc);
        return m_valid[i] && (m_tag[i] == m_tagof(m_pc));
    endfunction

    function automatic bit m_taken();
        return m_hit() && (m_ctr[m_idx(m_pc)] >= 2);
    endfunction

    function automatic bit [31:0] m_pred_pc();
        return m_taken() ? m_tgt[m_idx(m_pc)] : m_pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        bit [31:0] nxt;
        int        u;
        if (!rsn) begin
            m_pc = 32'h1000;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else begin
            if (bus.iret_i)
                nxt = bus.stall_core_i ? bus.exc_return_pc_i : bus.exc_return_pc_i + 32'd4;
            else if (bus.exc_occured_i) nxt = 32'h2000;
            else if (bus.mispred_i)     nxt = bus.redirect_pc_i;
            else if (bus.stall_core_i)  nxt = m_pc;
            else                        nxt = m_pred_pc();
            if (bus.upd_valid_i) begin
                u = m_idx(bus.upd_pc_i);
                if (m_valid[u] && m_tag[u] == m_tagof(bus.upd_pc_i)) begin
                    if (bus.upd_taken_i) begin
                        m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
                        m_tgt[u] = bus.upd_target_i;
                    end else begin
                        m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
                    end
                end else if (bus.upd_taken_i) begin
                    m_valid[u] = 1'b1;
                    m_tag[u]   = m_tagof(bus.upd_pc_i);
                    m_tgt[u]   = bus.upd_target_i;
                    m_ctr[u]   = 2;
                end
            end
            m_pc = nxt;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pc_o", bus.pc_o, m_pc);
            chk("pred_o", 32'(bus.pred_o), 32'(m_hit()));
            chk("taken_o", 32'(bus.taken_o), 32'(m_taken()));
            chk("pred_pc_o", bus.pred_pc_o, m_pred_pc());
        end
    end

    task automatic lit_pc(string nm, bit [31:0] exp);
        chk({nm, "_dut"}, bus.pc_o, exp);
        chk({nm, "_mdl"}, m_pc, exp);
    endtask

    task automatic lit_pred(string nm, bit p, bit t, bit [31:0] ppc);
        chk({nm, "_pred"}, 32'(bus.pred_o), 32'(p));
        chk({nm, "_taken"}, 32'(bus.taken_o), 32'(t));
        chk({nm, "_ppc"}, bus.pred_pc_o, ppc);
        chk({nm, "_mdl_taken"}, 32'(m_taken()), 32'(t));
        chk({nm, "_mdl_ppc"}, m_pred_pc(), ppc);
    endtask

    task automatic clr();
        bus.stall_core_i = 0; bus.iret_i = 0; bus.exc_occured_i = 0;
        bus.mispred_i = 0; bus.upd_valid_i = 0; bus.upd_taken_i = 0;
    endtask

    task automatic upd(bit [31:0] pc, bit [31:0] tgt, bit tk);
        bus.upd_valid_i = 1; bus.upd_pc_i = pc; bus.upd_target_i = tgt; bus.upd_taken_i = tk;
    endtask

    task automatic redir(bit [31:0] pc);
        bus.mispred_i = 1; bus.redirect_pc_i = pc;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        clr();
        bus.exc_return_pc_i = 0; bus.redirect_pc_i = 0;
        bus.upd_pc_i = 0; bus.upd_target_i = 0;
        rsn = 0;
        cyc();
        check_en = 1;
        // Reset and free run
        lit_pc("rst_pc", 32'h1000);
        lit_pred("rst", 0, 0, 32'h1004);
        rsn = 1;
        cyc(); lit_pc("run1", 32'h1004);
        cyc(); lit_pc("run2", 32'h1008);
        cyc(); lit_pc("run3", 32'h100C);
        // Allocate 0x1008 -> 0x1000 and fetch it
        upd(32'h1008, 32'h1000, 1); redir(32'h1008);
        cyc(); lit_pc("alloc_pc", 32'h1008); lit_pred("alloc", 1, 1, 32'h1000);
        clr();
        cyc(); lit_pc("follow", 32'h1000);
        // Counter walk, parked on 0x1008
        bus.stall_core_i = 1; redir(32'h1008); upd(32'h1008, 32'h1000, 0);
        cyc(); bus.mispred_i = 0;
        cyc(); lit_pc("park", 32'h1008); lit_pred("ctr00", 1, 0, 32'h100C);
        cyc(); lit_pred("ctr00_sat", 1, 0, 32'h100C);
        upd(32'h1008, 32'h1000, 1);
        cyc(); lit_pred("ctr01", 1, 0, 32'h100C);
        cyc(); lit_pred("ctr10", 1, 1, 32'h1000);
        cyc(); cyc();
        upd(32'h1008, 32'h1000, 0);
        cyc(); lit_pred("ctr11_dec", 1, 1, 32'h1000);
        cyc(); lit_pred("ctr01_again", 1, 0, 32'h100C);
        clr();
        // Exception beats mispredict and stall; iret with and without stall
        bus.exc_occured_i = 1; redir(32'h1008); bus.stall_core_i = 1;
        cyc(); lit_pc("exc", 32'h2000);
        clr(); bus.iret_i = 1; bus.exc_return_pc_i = 32'h1010;
        cyc(); lit_pc("iret", 32'h1014);
        bus.stall_core_i = 1;
        cyc(); lit_pc("iret_stall", 32'h1010);
        bus.iret_i = 0;
        cyc(); lit_pc("stall1", 32'h1010);
        cyc(); lit_pc("stall2", 32'h1010);
        cyc(); lit_pc("stall3", 32'h1010);
        redir(32'h1400);
        cyc(); lit_pc("mispred_stall", 32'h1400);
        // Alias replacement and wrap
        clr(); redir(32'h1048); upd(32'h1048, 32'h3000, 1);
        cyc(); lit_pc("alias_pc", 32'h1048); lit_pred("alias_new", 1, 1, 32'h3000);
        bus.upd_valid_i = 0; redir(32'h1008);
        cyc(); lit_pred("alias_old", 0, 0, 32'h100C);
        redir(32'hFFFF_FFFC);
        cyc(); lit_pc("top", 32'hFFFF_FFFC); lit_pred("top", 0, 0, 32'h0);
        clr();
        cyc(); lit_pc("wrap", 32'h0);
        // Reset overrides a training strobe
        rsn = 0; upd(32'h1000, 32'h1400, 1);
        cyc(); lit_pc("rst_mid", 32'h1000); lit_pred("rst_mid", 0, 0, 32'h1004);
        rsn = 1; clr();
        // Randomized traffic around a small address window so entries alias
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rsn                 = ($urandom_range(0, 199) != 0);
            bus.stall_core_i    = ($urandom_range(0, 4) == 0);
            bus.iret_i          = ($urandom_range(0, 29) == 0);
            bus.exc_occured_i   = ($urandom_range(0, 29) == 0);
            bus.mispred_i       = ($urandom_range(0, 9) == 0);
            bus.exc_return_pc_i = 32'h1000 + 4 * $urandom_range(0, 63);
            bus.redirect_pc_i   = 32'h1000 + 4 * $urandom_range(0, 63);
            bus.upd_valid_i     = ($urandom_range(0, 4) < 2);
            bus.upd_pc_i        = 32'h1000 + 4 * $urandom_range(0, 63);
            bus.upd_target_i    = 32'h1000 + 4 * $urandom_range(0, 63);
            bus.upd_taken_i     = $urandom_range(0, 1);
        end
        clr();
        cyc();
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
